// File: rtl/dmem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp_if
// Description : Request/response bundle between the MEM stage and dmem_resp.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_resp_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp
// Description : Single-outstanding data-memory responder with programmable
//               wait states, range/alignment checking and a pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int LATENCY = 2
) (
  input  wire logic  clk,
  input  wire logic  reset,
  dmem_resp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic        r_reqWe;
  logic [31:0] r_reqAddr;
  logic [31:0] r_reqWdata;
  logic        r_rspValid;
  logic [31:0] r_rspRdata;
  logic        r_rspErr;
  logic [31:0] r_mem [DEPTH];

  logic          w_ready;
  logic          w_accept;
  logic          w_enterResp;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_err;
  logic [AW-1:0] w_idx;

  assign w_ready  = (r_state == IDLE) || (r_state == RESP);
  assign w_accept = bus.req_valid && w_ready;

  // With zero wait states the access happens on the acceptance edge itself,
  // so it must use the live request rather than the not-yet-captured copy.
  assign w_we    = (LATENCY == 0) ? bus.req_we    : r_reqWe;
  assign w_addr  = (LATENCY == 0) ? bus.req_addr  : r_reqAddr;
  assign w_wdata = (LATENCY == 0) ? bus.req_wdata : r_reqWdata;

  assign w_enterResp = ((r_state == WAIT) && (r_count == 4'd1)) ||
                       ((LATENCY == 0) && w_accept);

  // Upper address bits only feed the range check, so aliasing is impossible.
  assign w_err = (w_addr[1:0] != 2'b00) || (w_addr[31:AW+2] != '0);
  assign w_idx = w_addr[AW+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_reqWe    <= 1'b0;
      r_reqAddr  <= 32'd0;
      r_reqWdata <= 32'd0;
      r_rspValid <= 1'b0;
      r_rspRdata <= 32'd0;
      r_rspErr   <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;

      if (w_accept) begin
        r_reqWe    <= bus.req_we;
        r_reqAddr  <= bus.req_addr;
        r_reqWdata <= bus.req_wdata;
      end

      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_count <= 4'(LATENCY);
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_state <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_enterResp) begin
        r_rspValid <= 1'b1;
        r_rspErr   <= w_err;
        if (w_err) begin
          r_rspRdata <= 32'd0;
        end else if (!w_we) begin
          r_rspRdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Array has no reset; a reset before RESP leaves the FSM idle, dropping the store.
  always_ff @(posedge clk) begin
    if (w_enterResp && w_we && !w_err) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_rdata = r_rspRdata;
  assign bus.rsp_err   = r_rspErr;
  assign bus.stall     = (r_state == WAIT) || (bus.req_valid && !r_rspValid);

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_resp
// Description : Directed self-checking bench; four responders at LATENCY 0/2/3/15.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

  localparam int LAT [4] = '{0, 2, 3, 15};

  logic        clk = 1'b0;
  logic [3:0]  resetN;
  logic [3:0]  reqValid;
  logic [3:0]  reqWe;
  logic [31:0] reqAddr  [4];
  logic [31:0] reqWdata [4];
  logic [3:0]  reqReady;
  logic [3:0]  rspValid;
  logic [31:0] rspRdata [4];
  logic [3:0]  rspErr;
  logic [3:0]  stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    dmem_resp_if bus ();
    assign bus.req_valid = reqValid[i];
    assign bus.req_we    = reqWe[i];
    assign bus.req_addr  = reqAddr[i];
    assign bus.req_wdata = reqWdata[i];
    assign reqReady[i]   = bus.req_ready;
    assign rspValid[i]   = bus.rsp_valid;
    assign rspRdata[i]   = bus.rsp_rdata;
    assign rspErr[i]     = bus.rsp_err;
    assign stall[i]      = bus.stall;

    dmem_resp #(.DEPTH(64), .AW(6), .LATENCY(LAT[i])) u_dut (
      .clk   (clk),
      .reset (resetN[i]),
      .bus   (bus)
    );
  end

  // Issues one request from an idle cycle; cyc = cycles until rsp_valid, -1 on timeout.
  task automatic issue(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int cyc,
                       output logic [31:0] rd, output logic er);
    @(negedge clk);
    reqValid[k] = 1'b1; reqWe[k] = we; reqAddr[k] = addr; reqWdata[k] = wdata;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rspValid[k] && cyc < 40);
    rd = rspRdata[k];
    er = rspErr[k];
    if (!rspValid[k]) cyc = -1;
    reqValid[k] = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 4'b0000; reqValid = 4'b0000; reqWe = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      reqAddr[k] = 32'd0; reqWdata[k] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({rspValid[k], rspRdata[k], rspErr[k], reqReady[k], stall[k]} !== {1'b0, 32'd0, 1'b0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL reset[%0d] got v=%b d=%h e=%b rdy=%b st=%b exp v=0 d=0 e=0 rdy=1 st=0",
                 k, rspValid[k], rspRdata[k], rspErr[k], reqReady[k], stall[k]);
      end
    end
    resetN = 4'b1111;
  endtask

  task automatic test_load();
    int cyc; logic [31:0] rd; logic er;
    issue(1, 1'b1, 32'h14, 32'hDEADBEEF, cyc, rd, er);
    checks++;
    if ({cyc[7:0], er} !== {8'd3, 1'b0}) begin
      failures++; $display("FAIL load_preload got cyc=%0d err=%b exp cyc=3 err=0", cyc, er);
    end
    @(negedge clk);
    reqValid[1] = 1'b1; reqWe[1] = 1'b0; reqAddr[1] = 32'h14; reqWdata[1] = 32'h0;
    #1;
    checks++;
    if ({stall[1], reqReady[1], rspValid[1]} !== 3'b110) begin
      failures++; $display("FAIL load_c0 got st/rdy/v=%b%b%b exp 110", stall[1], reqReady[1], rspValid[1]);
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if ({stall[1], reqReady[1], rspValid[1]} !== 3'b100) begin
        failures++; $display("FAIL load_c%0d got st/rdy/v=%b%b%b exp 100", c, stall[1], reqReady[1], rspValid[1]);
      end
    end
    @(negedge clk);
    checks++;
    if ({rspValid[1], rspRdata[1], rspErr[1], stall[1], reqReady[1]} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL load_c3 got v=%b d=%h e=%b st=%b rdy=%b exp v=1 d=deadbeef e=0 st=0 rdy=1",
                           rspValid[1], rspRdata[1], rspErr[1], stall[1], reqReady[1]);
    end
    reqValid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({rspValid[1], rspRdata[1], rspErr[1], stall[1], reqReady[1]} !== {1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL load_c4 got v=%b d=%h e=%b st=%b rdy=%b exp v=0 d=deadbeef e=0 st=0 rdy=1",
                           rspValid[1], rspRdata[1], rspErr[1], stall[1], reqReady[1]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    reqValid[0] = 1'b1; reqWe[0] = 1'b1; reqAddr[0] = 32'h8; reqWdata[0] = 32'h12345678;
    #1;
    checks++;
    if (stall[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_stall got %b exp 1", stall[0]);
    end
    @(negedge clk);
    checks++;
    if ({rspValid[0], rspErr[0], rspRdata[0]} !== {1'b1, 1'b0, 32'd0}) begin
      failures++; $display("FAIL b2b_store got v=%b e=%b d=%h exp v=1 e=0 d=0", rspValid[0], rspErr[0], rspRdata[0]);
    end
    reqWe[0] = 1'b0; reqWdata[0] = 32'h0;
    @(negedge clk);
    checks++;
    if ({rspValid[0], rspErr[0], rspRdata[0]} !== {1'b1, 1'b0, 32'h12345678}) begin
      failures++; $display("FAIL b2b_load got v=%b e=%b d=%h exp v=1 e=0 d=12345678", rspValid[0], rspErr[0], rspRdata[0]);
    end
    reqValid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({rspValid[0], rspRdata[0]} !== {1'b0, 32'h12345678}) begin
      failures++; $display("FAIL b2b_idle got v=%b d=%h exp v=0 d=12345678", rspValid[0], rspRdata[0]);
    end
  endtask

  task automatic test_misaligned();
    int cyc; logic [31:0] rd; logic er;
    issue(1, 1'b1, 32'h4, 32'hA5A5A5A5, cyc, rd, er);
    checks++;
    if ({cyc[7:0], rd, er} !== {8'd3, 32'hDEADBEEF, 1'b0}) begin
      failures++; $display("FAIL mis_preload got cyc=%0d d=%h e=%b exp cyc=3 d=deadbeef e=0", cyc, rd, er);
    end
    issue(1, 1'b1, 32'h6, 32'hFFFFFFFF, cyc, rd, er);
    checks++;
    if ({cyc[7:0], rd, er} !== {8'd3, 32'h0, 1'b1}) begin
      failures++; $display("FAIL mis_store got cyc=%0d d=%h e=%b exp cyc=3 d=0 e=1", cyc, rd, er);
    end
    issue(1, 1'b0, 32'h4, 32'h0, cyc, rd, er);
    checks++;
    if ({cyc[7:0], rd, er} !== {8'd3, 32'hA5A5A5A5, 1'b0}) begin
      failures++; $display("FAIL mis_readback got cyc=%0d d=%h e=%b exp cyc=3 d=a5a5a5a5 e=0", cyc, rd, er);
    end
  endtask

  task automatic test_out_of_range();
    int cyc; logic [31:0] rd; logic er;
    issue(1, 1'b0, 32'h100, 32'h0, cyc, rd, er);
    checks++;
    if ({cyc[7:0], rd, er} !== {8'd3, 32'h0, 1'b1}) begin
      failures++; $display("FAIL oor_100 got cyc=%0d d=%h e=%b exp cyc=3 d=0 e=1", cyc, rd, er);
    end
    issue(1, 1'b0, 32'h114, 32'h0, cyc, rd, er);
    checks++;
    if ({rd, er} !== {32'h0, 1'b1}) begin
      failures++; $display("FAIL oor_alias got d=%h e=%b exp d=0 e=1", rd, er);
    end
    issue(1, 1'b1, 32'hFC, 32'hCAFEF00D, cyc, rd, er);
    issue(1, 1'b0, 32'hFC, 32'h0, cyc, rd, er);
    checks++;
    if ({rd, er} !== {32'hCAFEF00D, 1'b0}) begin
      failures++; $display("FAIL oor_top_word got d=%h e=%b exp d=cafef00d e=0", rd, er);
    end
    issue(1, 1'b0, 32'h14, 32'h0, cyc, rd, er);
    checks++;
    if ({rd, er} !== {32'hDEADBEEF, 1'b0}) begin
      failures++; $display("FAIL oor_next got d=%h e=%b exp d=deadbeef e=0", rd, er);
    end
  endtask

  task automatic test_reset_mid_wait();
    int cyc; logic [31:0] rd; logic er;
    issue(2, 1'b1, 32'h0, 32'h11111111, cyc, rd, er);
    issue(2, 1'b0, 32'h0, 32'h0, cyc, rd, er);
    checks++;
    if ({cyc[7:0], rd, er} !== {8'd4, 32'h11111111, 1'b0}) begin
      failures++; $display("FAIL rst_preload got cyc=%0d d=%h e=%b exp cyc=4 d=11111111 e=0", cyc, rd, er);
    end
    @(negedge clk);
    reqValid[2] = 1'b1; reqWe[2] = 1'b1; reqAddr[2] = 32'h0; reqWdata[2] = 32'h22222222;
    @(negedge clk);
    checks++;
    if ({reqReady[2], stall[2]} !== 2'b01) begin
      failures++; $display("FAIL rst_wait got rdy=%b st=%b exp rdy=0 st=1", reqReady[2], stall[2]);
    end
    resetN[2] = 1'b0; reqValid[2] = 1'b0;
    #1;
    checks++;
    if ({rspValid[2], rspRdata[2], rspErr[2], stall[2], reqReady[2]} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL rst_async got v=%b d=%h e=%b st=%b rdy=%b exp v=0 d=0 e=0 st=0 rdy=1",
                           rspValid[2], rspRdata[2], rspErr[2], stall[2], reqReady[2]);
    end
    repeat (2) @(negedge clk);
    resetN[2] = 1'b1;
    issue(2, 1'b0, 32'h0, 32'h0, cyc, rd, er);
    checks++;
    if ({cyc[7:0], rd, er} !== {8'd4, 32'h11111111, 1'b0}) begin
      failures++; $display("FAIL rst_mem_kept got cyc=%0d d=%h e=%b exp cyc=4 d=11111111 e=0", cyc, rd, er);
    end
  endtask

  task automatic test_input_hold();
    int cyc; logic [31:0] rd; logic er;
    issue(3, 1'b1, 32'h20, 32'h0BADF00D, cyc, rd, er);
    issue(3, 1'b1, 32'h24, 32'h77777777, cyc, rd, er);
    @(negedge clk);
    reqValid[3] = 1'b1; reqWe[3] = 1'b0; reqAddr[3] = 32'h20; reqWdata[3] = 32'h0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        reqWe[3] = 1'b1; reqAddr[3] = 32'h24; reqWdata[3] = 32'hFFFFFFFF;
      end
    end while (!rspValid[3] && cyc < 40);
    checks++;
    if ({rspValid[3], cyc[7:0], rspRdata[3], rspErr[3]} !== {1'b1, 8'd16, 32'h0BADF00D, 1'b0}) begin
      failures++; $display("FAIL hold_rsp got v=%b cyc=%0d d=%h e=%b exp v=1 cyc=16 d=0badf00d e=0",
                           rspValid[3], cyc, rspRdata[3], rspErr[3]);
    end
    reqValid[3] = 1'b0;
    issue(3, 1'b0, 32'h24, 32'h0, cyc, rd, er);
    checks++;
    if ({cyc[7:0], rd, er} !== {8'd16, 32'h77777777, 1'b0}) begin
      failures++; $display("FAIL hold_nowrite got cyc=%0d d=%h e=%b exp cyc=16 d=77777777 e=0", cyc, rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_misaligned();
    test_out_of_range();
    test_reset_mid_wait();
    test_input_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
